device_req_arbiter: RTL and testbench

Shares one DPI device-helper access port between NUM_REQ requesters, such as the MMIO paths of multiple cores or a debug/bus bridge. Requesters are selected round-robin. The block holds one transaction in flight and pulses the device request for exactly one cycle. It captures the read data returned by the device in the following cycle and delivers it to the granted requester with a valid/ready handshake.

---
 rtl/device_req_arbiter.sv | 131 +++++++++++++
 tb/tb_device_req_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/device_req_arbiter.sv
// Round-robin arbiter sharing one device-helper access port between NUM_REQ requesters.
// One transaction in flight: accept -> one-cycle device strobe -> capture read data -> respond.
module device_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_valid,
  output logic [NUM_REQ-1:0]        in_ready,
  input  logic [NUM_REQ-1:0]        in_wen,
  input  logic [NUM_REQ*ADDR_W-1:0] in_addr,
  input  logic [NUM_REQ*DATA_W-1:0] in_wdata,
  input  logic [NUM_REQ*8-1:0]      in_wmask,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      dev_req_valid,
  output logic                      dev_req_wen,
  output logic [63:0]               dev_req_addr,
  output logic [63:0]               dev_req_wdata,
  output logic [7:0]                dev_req_wmask,
  input  logic [63:0]               dev_resp_rdata,
  output logic                      busy
);

  localparam int          IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, id_q, win;
  logic             any_valid, accept, handshake;
  logic             wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [7:0]       wmask_q;

  // Search from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    int unsigned    sum;
    logic [IDW-1:0] idx;
    sum       = 0;
    idx       = '0;
    win       = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NREQ_U) sum = sum - NREQ_U;
      idx = IDW'(sum);
      if (!any_valid && in_valid[idx]) begin
        any_valid = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = '0;
    resp_valid    = '0;
    resp_rdata    = '0;
    dev_req_valid = 1'b0;
    dev_req_wen   = 1'b0;
    dev_req_addr  = '0;
    dev_req_wdata = '0;
    dev_req_wmask = '0;
    accept        = 1'b0;
    handshake     = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept        = 1'b1;
          in_ready[win] = 1'b1;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        dev_req_valid = 1'b1;
        dev_req_wen   = wen_q;
        dev_req_addr  = 64'(addr_q);
        dev_req_wdata = 64'(wdata_q);
        dev_req_wmask = wmask_q;
        state_nxt     = WAIT;
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        resp_valid[id_q] = 1'b1;
        resp_rdata       = rdata_q;
        if (resp_ready[id_q]) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Handshake outputs are suppressed for the whole reset cycle, not just after it.
    if (reset) begin
      in_ready   = '0;
      resp_valid = '0;
    end
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_q    <= win;
        wen_q   <= in_wen[win];
        addr_q  <= in_addr[int'(win)*ADDR_W +: ADDR_W];
        wdata_q <= in_wdata[int'(win)*DATA_W +: DATA_W];
        wmask_q <= in_wmask[int'(win)*8 +: 8];
      end
      if (state == WAIT) rdata_q <= wen_q ? '0 : DATA_W'(dev_resp_rdata);
      if (handshake) rr_ptr <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
    end
  end

endmodule

// File: tb/tb_device_req_arbiter.sv
// Scoreboard bench for device_req_arbiter: expected transactions are queued as requests are
// posted and checked at grant, device strobe and response handshake.
module tb_device_req_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_valid, in_ready, in_wen, resp_valid, resp_ready;
  logic [N*64-1:0]  in_addr, in_wdata;
  logic [N*8-1:0]   in_wmask;
  logic [63:0]      resp_rdata;
  logic             dev_req_valid, dev_req_wen, busy;
  logic [63:0]      dev_req_addr, dev_req_wdata, dev_resp_rdata;
  logic [7:0]       dev_req_wmask;

  typedef struct {
    int          id;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   grant_cycles[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, grant_cyc = 0, issued = 0;
  bit   live = 1'b0, resp_on = 1'b0;

  device_req_arbiter #(.NUM_REQ(N), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_wmask(in_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .dev_req_valid(dev_req_valid), .dev_req_wen(dev_req_wen), .dev_req_addr(dev_req_addr),
    .dev_req_wdata(dev_req_wdata), .dev_req_wmask(dev_req_wmask),
    .dev_resp_rdata(dev_resp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dev_fn(input logic [63:0] a);
    return a ^ 64'hDEAD_BEEF_4000_1234;
  endfunction

  function automatic logic [N-1:0] onehot(input int id);
    return N'(1) << id;
  endfunction

  function automatic exp_t mk(input int i, input logic wen, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] wmask);
    exp_t e;
    e.id = i; e.wen = wen; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
    e.rdata = wen ? 64'h0 : dev_fn(addr);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Device returns data the cycle after its strobe; anything else is poison.
  always @(posedge clk)
    dev_resp_rdata <= dev_req_valid ? dev_fn(dev_req_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      live = 1'b0; resp_on = 1'b0; issued = 0;
    end else begin
      if (exp_q.size() != 0) cur = exp_q[0];
      if ((in_ready & in_valid) != '0) begin
        if (exp_q.size() == 0) check("grant_unexpected", 64'(in_ready), 64'(0));
        else begin
          check("grant_id", 64'(in_ready), 64'(onehot(cur.id)));
          live = 1'b1; resp_on = 1'b0; issued = 0; grant_cyc = cyc;
          grant_cycles.push_back(cyc);
        end
      end
      if (dev_req_valid) begin
        if (!live) check("issue_unexpected", 64'(dev_req_valid), 64'(0));
        else begin
          issued++;
          check("issue_latency", 64'(cyc - grant_cyc), 64'(1));
          check("dev_wen", 64'(dev_req_wen), 64'(cur.wen));
          check("dev_addr", dev_req_addr, cur.addr);
          check("dev_wdata", dev_req_wdata, cur.wdata);
          check("dev_wmask", 64'(dev_req_wmask), 64'(cur.wmask));
        end
      end
      if (resp_valid != '0) begin
        if (!live) check("resp_unexpected", 64'(resp_valid), 64'(0));
        else begin
          if (!resp_on) begin
            check("resp_latency", 64'(cyc - grant_cyc), 64'(3));
            check("dev_pulses", 64'(issued), 64'(1));
            resp_on = 1'b1;
          end
          check("resp_valid", 64'(resp_valid), 64'(onehot(cur.id)));
          check("resp_rdata", resp_rdata, cur.rdata);
          if (resp_ready[cur.id]) begin
            void'(exp_q.pop_front());
            live = 1'b0;
          end
        end
      end
    end
  end

  task automatic set_fields(input int i, input logic wen, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wmask);
    in_wen[i]            = wen;
    in_addr[i*64 +: 64]  = addr;
    in_wdata[i*64 +: 64] = wdata;
    in_wmask[i*8 +: 8]   = wmask;
  endtask

  task automatic post(input int i, input logic wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask);
    set_fields(i, wen, addr, wdata, wmask);
    exp_q.push_back(mk(i, wen, addr, wdata, wmask));
    in_valid[i] = 1'b1;
  endtask

  // Waits for requester i to be granted, then withdraws and scrambles its inputs.
  task automatic wait_grant(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (in_ready[i]) got = 1'b1;
    end
    check($sformatf("grant%0d_seen", i), 64'(got), 64'(1));
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    set_fields(i, ~in_wen[i], {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          g0;
    bit          seen;
    logic [63:0] held;
    reset = 1'b1; in_valid = '1; in_wen = '0; in_addr = '0; in_wdata = '0; in_wmask = '0;
    resp_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0; in_valid = '0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_dev_valid", 64'(dev_req_valid), 64'(0));
    check("idle_dev_addr", dev_req_addr, 64'(0));
    check("idle_resp_rdata", resp_rdata, 64'(0));
    check("idle_in_ready", 64'(in_ready), 64'(0));

    // Round-robin with every requester continuously valid.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      set_fields(i, 1'(i % 2), 64'h1000_0000 + 64'(i * 256), 64'hC0DE_0000 + 64'(i), 8'(1 << i));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        exp_q.push_back(mk(i, 1'(i % 2), 64'h1000_0000 + 64'(i * 256), 64'hC0DE_0000 + 64'(i),
                           8'(1 << i)));
    g0 = grant_cycles.size();
    in_valid = '1;
    wait_drain(60);
    in_valid = '0;
    check("rr_grants", 64'(grant_cycles.size() - g0), 64'(8));
    for (int k = 0; k < 7; k++)
      if (g0 + k + 1 < grant_cycles.size())
        check("rr_spacing", 64'(grant_cycles[g0+k+1] - grant_cycles[g0+k]), 64'(4));

    // Single read, then a write whose response data must be zero.
    post(1, 1'b0, 64'h4000_0000, 64'h1357, 8'hFF);
    wait_grant(1);
    wait_drain(20);
    post(0, 1'b1, 64'h1000, 64'h55AA, 8'h0F);
    wait_grant(0);
    wait_drain(20);

    // Backpressure on req2, then wrap from rr_ptr=3 with req1 and req2 competing.
    resp_ready = 4'b1011;
    post(2, 1'b0, 64'h2000_0040, 64'h0, 8'h00);
    wait_grant(2);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid[2]) seen = 1'b1;
    end
    check("bp_resp_seen", 64'(seen), 64'(1));
    held = resp_rdata;
    check("bp_rdata", held, dev_fn(64'h2000_0040));
    @(posedge clk); #1;
    post(1, 1'b0, 64'h1111_0008, 64'h9, 8'hA5);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid_hold", 64'(resp_valid), 64'(4'b0100));
      check("bp_rdata_hold", resp_rdata, held);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_no_issue", 64'(dev_req_valid), 64'(0));
    end
    @(posedge clk); #1;
    post(2, 1'b1, 64'h2000_0080, 64'hABCD, 8'h3C);
    resp_ready[2] = 1'b1;
    wait_grant(1);
    wait_grant(2);
    wait_drain(20);

    // Reset while a read waits for device data.
    post(3, 1'b0, 64'h3000_0000, 64'h77, 8'hF0);
    wait_grant(3);
    @(negedge clk);
    check("mid_issue", 64'(dev_req_valid), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    set_fields(0, 1'b0, 64'h0BAD_0000, 64'h42, 8'h81);
    in_valid = '1;
    @(negedge clk);
    check("mid_rst_resp", 64'(resp_valid), 64'(0));
    check("mid_rst_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(mk(0, 1'b0, 64'h0BAD_0000, 64'h42, 8'h81));
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_grant", 64'(in_ready), 64'(4'b0001));
    check("post_rst_dev", 64'(dev_req_valid), 64'(0));
    check("post_rst_resp", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    in_valid = '0;
    wait_drain(20);
    repeat (4) begin
      @(negedge clk);
      check("end_resp_valid", 64'(resp_valid), 64'(0));
      check("end_busy", 64'(busy), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
